caravel_la_sram_test: RTL and testbench

Self-checking SRAM test sequencer for the OpenRAM test chip user area, driven from the logic-analyzer (LA) test path. On a start pulse it visits every enabled SRAM macro in turn. For each macro it writes a deterministic pattern over a window of addresses, reads the window back and compares. Results go to GPIO status pins: `active` → mprj_io[25]; `mismatch[0..5]` → io[26..31]; `mismatch[8..10]` → io[34..36]. The firmware image in the SPI flash (loaded into the bench's flash model) only pulses `start`; all checking happens in this block.

---
 rtl/caravel_la_sram_test.sv | 180 ++++++++++++++++++
 tb/tb_caravel_la_sram_test.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/caravel_la_sram_test.sv
// rtl/caravel_la_sram_test.sv - LA-driven SRAM write/read-back test sequencer for the OpenRAM user area
module caravel_la_sram_test #(
    parameter int                     NUM_SRAM  = 16,
    parameter logic [NUM_SRAM-1:0]    SRAM_MASK = 16'h073F,
    parameter int                     ADDR_W    = 8,
    parameter int                     DATA_W    = 32,
    parameter int                     NWORDS    = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  test_mode,
    input  logic                  start,
    output logic [3:0]            sram_sel,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [DATA_W/8-1:0]   sram_wmask,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_din,
    input  logic [DATA_W-1:0]     sram_dout,
    output logic                  active,
    output logic                  done,
    output logic [NUM_SRAM-1:0]   mismatch
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_WRITE,
        S_READ,
        S_CMP,
        S_FINISH
    } state_t;

    localparam logic [3:0]        LAST_M = 4'(NUM_SRAM - 1);
    localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(NWORDS - 1);

    // Byte pattern depends on macro and address so aliased or swapped macros show up.
    function automatic logic [DATA_W-1:0] pattern(input logic [3:0] m, input logic [ADDR_W-1:0] i);
        logic [7:0] b;
        b = 8'(i) * 8'h25 + 8'(m) * 8'h11 + 8'h5A;
        return {(DATA_W/8){b}};
    endfunction

    state_t               state, state_nx;
    logic [3:0]           m, m_nx;
    logic [ADDR_W-1:0]    idx, idx_nx;
    logic                 start_q;
    logic                 cmp_v, cmp_v_nx;
    logic [3:0]           cmp_m, cmp_m_nx;
    logic [ADDR_W-1:0]    cmp_idx, cmp_idx_nx;
    logic                 active_nx, done_nx;
    logic [NUM_SRAM-1:0]  mismatch_nx;
    logic                 csb_nx, web_nx;
    logic [DATA_W/8-1:0]  wmask_nx;
    logic [ADDR_W-1:0]    addr_nx;
    logic [DATA_W-1:0]    din_nx;
    logic                 start_edge, abort, access;

    assign start_edge = start & ~start_q;

    always_comb begin
        state_nx    = state;
        m_nx        = m;
        idx_nx      = idx;
        cmp_v_nx    = 1'b0;
        cmp_m_nx    = cmp_m;
        cmp_idx_nx  = cmp_idx;
        done_nx     = done;
        mismatch_nx = mismatch;
        abort       = test_mode && (state inside {S_SEL, S_WRITE, S_READ, S_CMP});

        // Read data for the request issued last cycle is checked here.
        if (cmp_v && !abort && (sram_dout != pattern(cmp_m, cmp_idx)))
            mismatch_nx[cmp_m] = 1'b1;

        case (state)
            S_IDLE: begin
                if (start_edge && !test_mode) begin
                    state_nx    = S_SEL;
                    m_nx        = '0;
                    idx_nx      = '0;
                    mismatch_nx = '0;
                    done_nx     = 1'b0;
                end
            end
            S_SEL: begin
                idx_nx = '0;
                if (SRAM_MASK[m])
                    state_nx = S_WRITE;
                else if (m == LAST_M)
                    state_nx = S_FINISH;
                else
                    m_nx = m + 4'd1;
            end
            S_WRITE: begin
                if (idx == LAST_I) begin
                    state_nx = S_READ;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            S_READ: begin
                cmp_v_nx   = 1'b1;
                cmp_m_nx   = m;
                cmp_idx_nx = idx;
                if (idx == LAST_I)
                    state_nx = S_CMP;
                else
                    idx_nx = idx + 1'b1;
            end
            S_CMP: begin
                if (m == LAST_M) begin
                    state_nx = S_FINISH;
                end else begin
                    state_nx = S_SEL;
                    m_nx     = m + 4'd1;
                end
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase

        if (abort) begin
            state_nx = S_IDLE;
            idx_nx   = '0;
            cmp_v_nx = 1'b0;
        end

        // Outputs are computed from the next state so the registered copies line up with it.
        active_nx = state_nx inside {S_SEL, S_WRITE, S_READ, S_CMP};
        if (state_nx == S_FINISH)
            done_nx = 1'b1;
        access   = state_nx inside {S_WRITE, S_READ};
        csb_nx   = ~access;
        web_nx   = (state_nx != S_WRITE);
        wmask_nx = (state_nx == S_WRITE) ? '1 : '0;
        addr_nx  = access ? idx_nx : '0;
        din_nx   = (state_nx == S_WRITE) ? pattern(m_nx, idx_nx) : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            m          <= '0;
            idx        <= '0;
            start_q    <= 1'b0;
            cmp_v      <= 1'b0;
            cmp_m      <= '0;
            cmp_idx    <= '0;
            active     <= 1'b0;
            done       <= 1'b0;
            mismatch   <= '0;
            sram_sel   <= '0;
            sram_csb   <= 1'b1;
            sram_web   <= 1'b1;
            sram_wmask <= '0;
            sram_addr  <= '0;
            sram_din   <= '0;
        end else begin
            state      <= state_nx;
            m          <= m_nx;
            idx        <= idx_nx;
            start_q    <= start;
            cmp_v      <= cmp_v_nx;
            cmp_m      <= cmp_m_nx;
            cmp_idx    <= cmp_idx_nx;
            active     <= active_nx;
            done       <= done_nx;
            mismatch   <= mismatch_nx;
            sram_sel   <= m_nx;
            sram_csb   <= csb_nx;
            sram_web   <= web_nx;
            sram_wmask <= wmask_nx;
            sram_addr  <= addr_nx;
            sram_din   <= din_nx;
        end
    end

endmodule

// File: tb/tb_caravel_la_sram_test.sv
// tb/tb_caravel_la_sram_test.sv - scoreboard bench for caravel_la_sram_test with per-macro SRAM model
module tb_caravel_la_sram_test;

    localparam logic [15:0] MASK      = 16'h073F;
    localparam int          RUN_CYCLES = 9 * (2 * 16 + 2) + 7;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        test_mode = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  sram_sel;
    logic        sram_csb, sram_web;
    logic [3:0]  sram_wmask;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = '0;
    logic        active, done;
    logic [15:0] mismatch;

    always #5 clk = ~clk;

    caravel_la_sram_test dut (
        .clk        (clk),
        .resetn     (resetn),
        .test_mode  (test_mode),
        .start      (start),
        .sram_sel   (sram_sel),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout),
        .active     (active),
        .done       (done),
        .mismatch   (mismatch)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int m, input int i);
        logic [7:0] b;
        b = 8'(i * 37 + m * 17 + 90);
        return {4{b}};
    endfunction

    // Ideal 1-cycle-latency SRAM array per macro, with an optional single-bit read fault.
    logic [31:0] mem [0:15][0:255];
    int fault_m = -1;
    int fault_a = -1;

    always @(posedge clk) begin
        if (resetn && !sram_csb) begin
            if (!sram_web) begin
                for (int k = 0; k < 4; k++)
                    if (sram_wmask[k])
                        mem[sram_sel][sram_addr][8*k +: 8] <= sram_din[8*k +: 8];
            end else begin
                sram_dout <= mem[sram_sel][sram_addr] ^
                    {31'b0, (int'(sram_sel) == fault_m) && (int'(sram_addr) == fault_a)};
            end
        end
    end

    logic [47:0] wr_q [$];
    logic [47:0] res_q [$];
    int          act_cycles = 0;

    always @(negedge clk) begin
        if (resetn) begin
            if (active)
                act_cycles++;
            if (!sram_csb)
                check("csb_on_masked_sel", 64'(MASK[sram_sel]), 64'd1);
            if (!sram_csb && !sram_web) begin
                if (wr_q.size() == 0)
                    check("unexpected_write", 64'd1, 64'd0);
                else
                    check("write_txn", 64'({sram_sel, sram_addr, sram_din, sram_wmask}), 64'(wr_q.pop_front()));
            end
        end
    end

    task automatic start_run(input logic [15:0] exp_mm);
        for (int m = 0; m < 16; m++)
            if (MASK[m])
                for (int i = 0; i < 16; i++)
                    wr_q.push_back({4'(m), 8'(i), pat(m, i), 4'hF});
        res_q.push_back({exp_mm, 32'(RUN_CYCLES)});
        act_cycles = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("active_rise", 64'(active), 64'd1);
        start = 1'b0;
    endtask

    task automatic wait_done();
        logic [47:0] r;
        for (int k = 0; k < 2000 && !done; k++)
            @(negedge clk);
        check("done_before_timeout", 64'(done), 64'd1);
        r = res_q.pop_front();
        check("mismatch_final", 64'(mismatch), 64'(r[47:32]));
        check("active_cycles", 64'(act_cycles), 64'(r[31:0]));
        check("active_low_at_done", 64'(active), 64'd0);
        check("writes_left", 64'(wr_q.size()), 64'd0);
    endtask

    initial begin
        int cnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("reset_csb", 64'(sram_csb), 64'd1);
        end
        check("reset_outs", 64'({active, done, mismatch, sram_web, sram_wmask, sram_addr, sram_din, sram_sel}),
              64'({1'b0, 1'b0, 16'h0, 1'b1, 4'h0, 8'h0, 32'h0, 4'h0}));
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_csb", 64'(sram_csb), 64'd1);

        start_run(16'h0000);
        wait_done();
        check("mem_m0_a3", 64'(mem[0][3]), 64'(pat(0, 3)));
        check("mem_m10_a15", 64'(mem[10][15]), 64'(pat(10, 15)));

        fault_m = 9; fault_a = 7;
        start_run(16'h0200);
        wait_done();

        // Reset during macro 2 read-back; macro 1 fault is already flagged by then.
        fault_m = 1; fault_a = 0;
        start_run(16'h0002);
        cnt = 0;
        while (cnt < 2000 && !(sram_sel == 4'd2 && !sram_csb && sram_web)) begin
            @(negedge clk);
            cnt++;
        end
        check("reached_m2_read", 64'(cnt < 2000), 64'd1);
        check("m1_flag_before_reset", 64'(mismatch), 64'h0002);
        #2 resetn = 1'b0;
        #1;
        check("async_reset_active", 64'(active), 64'd0);
        check("async_reset_mismatch", 64'(mismatch), 64'd0);
        check("async_reset_csb", 64'(sram_csb), 64'd1);
        wr_q.delete();
        res_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        fault_m = -1; fault_a = -1;
        start_run(16'h0000);
        wait_done();

        // start edge while in scan mode must not launch a run.
        test_mode = 1'b1;
        @(negedge clk);
        start = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!sram_csb || active)
                cnt++;
        end
        check("scan_mode_no_access", 64'(cnt), 64'd0);
        start = 1'b0;
        @(negedge clk);
        test_mode = 1'b0;

        fault_m = 1; fault_a = 0;
        start_run(16'h0002);
        repeat (80) @(negedge clk);
        check("midrun_active", 64'(active), 64'd1);
        test_mode = 1'b1;
        @(negedge clk);
        check("abort_active", 64'(active), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_mismatch_kept", 64'(mismatch), 64'h0002);
        check("abort_csb", 64'(sram_csb), 64'd1);
        wr_q.delete();
        res_q.delete();
        repeat (5) @(negedge clk);
        check("abort_done_stays", 64'(done), 64'd0);
        test_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
